// File: rtl/cpu_speed_pkg.sv
// cpu_speed_pkg: shared state encodings, mux select constants and width helper
// for the CPU speed switch controller.
package cpu_speed_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_BUS = 2'd1,
      ST_SWITCH   = 2'd2,
      ST_SETTLE   = 2'd3
   } state_e;

   localparam logic SEL_CLK1 = 1'b1;
   localparam logic SEL_CLK2 = 1'b0;

   // Bits needed to hold values 0..v-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchroniser followed by a debounce counter; the output
// only follows the input after DEBOUNCE_CYCLES consecutive stable cycles.
module sync_debounce
   import cpu_speed_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 65536,
   parameter logic        RESET_VAL       = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   localparam int unsigned     CW      = clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          sw_s;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign sw_s = sync_q[1];
   assign q_o  = db_q;

   // Any sample matching the accepted level restarts the stability window.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sw_s != db_q) begin
         if (cnt_q == CNT_MAX) db_d = sw_s;
         else cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {2{RESET_VAL}};
         db_q   <= RESET_VAL;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], d_i};
         db_q   <= db_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_speed_ctrl.sv
// cpu_speed_ctrl: drives the glitch-free CPU clock mux select from the debounced
// panel switch, changing it only while the 68000 bus is idle.
module cpu_speed_ctrl
   import cpu_speed_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 65536,
   parameter int unsigned SETTLE_CYCLES   = 16,
   parameter int unsigned IDLE_CYCLES     = 2
) (
   input  logic CLK,
   input  logic RESET_n,
   input  logic SWITCH_n,
   input  logic AS_n,
   output logic CPU_SPEED_SWITCH,
   output logic FAST,
   output logic BUSY
);

   localparam int unsigned   IW          = clog2(IDLE_CYCLES + 1);
   localparam int unsigned   SW          = clog2(SETTLE_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_DONE   = IW'(IDLE_CYCLES);
   localparam logic [SW-1:0] SETTLE_DONE = SW'(SETTLE_CYCLES);

   state_e        state_q, state_d;
   logic          sel_q, sel_d;
   logic [IW-1:0] idle_q, idle_d, idle_inc;
   logic [SW-1:0] settle_q, settle_d, settle_inc;
   logic [1:0]    as_sync_q;
   logic          as_s, sw_db;

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_sw (
      .clk_i  (CLK),
      .rst_ni (RESET_n),
      .d_i    (SWITCH_n),
      .q_o    (sw_db)
   );

   assign as_s       = as_sync_q[1];
   assign idle_inc   = idle_q + 1'b1;
   assign settle_inc = settle_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      idle_d   = '0;
      settle_d = '0;
      case (state_q)
         ST_IDLE:     if (sw_db != sel_q) state_d = ST_WAIT_BUS;
         ST_WAIT_BUS: begin
            idle_d = as_s ? idle_inc : '0;
            // A reverted switch wins over a completing idle window.
            if (sw_db == sel_q) state_d = ST_IDLE;
            else if (as_s && idle_inc == IDLE_DONE) state_d = ST_SWITCH;
         end
         ST_SWITCH:   begin
            sel_d   = sw_db;
            state_d = ST_SETTLE;
         end
         ST_SETTLE:   begin
            settle_d = settle_inc;
            if (settle_inc == SETTLE_DONE) state_d = ST_IDLE;
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q   <= ST_IDLE;
         sel_q     <= SEL_CLK1;
         idle_q    <= '0;
         settle_q  <= '0;
         as_sync_q <= 2'b11;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         idle_q    <= idle_d;
         settle_q  <= settle_d;
         as_sync_q <= {as_sync_q[0], AS_n};
      end
   end

   assign CPU_SPEED_SWITCH = sel_q;
   assign FAST             = (sel_q == SEL_CLK2);
   assign BUSY             = (state_q != ST_IDLE);

endmodule
